// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: registered RV32I/RV64I branch resolution with optional BHT (macro BRANCH_BHT_EN)
module branch_resolve_unit #(
  parameter int XLEN      = 32,
  parameter int BHT_DEPTH = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [XLEN-1:0] in_imm,
  input  logic [2:0]      in_f3,
  input  logic            in_pred_taken,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_taken,
  output logic [XLEN-1:0] out_target,
  output logic [XLEN-1:0] out_redirect_pc,
  output logic            out_mispredict,
  output logic            out_illegal,
  input  logic [XLEN-1:0] pred_pc,
  output logic            pred_taken,
  output logic [31:0]     perf_branches,
  output logic [31:0]     perf_mispredicts
);
  logic            r_valid, r_taken, r_misp, r_illegal;
  logic [XLEN-1:0] r_target, r_redirect;
  logic [31:0]     r_nbr, r_nmis;
  logic            w_accept, w_retire, w_taken, w_illegal, w_eq, w_lt, w_ltu;
  logic [XLEN-1:0] w_target, w_seq;
  logic            w_pred_unused;
  assign in_ready  = !flush && (!r_valid || out_ready);
  assign w_accept  = in_valid && in_ready;
  assign w_retire  = r_valid && out_ready && !flush;
  assign w_eq      = in_rs1 == in_rs2;
  assign w_lt      = $signed(in_rs1) < $signed(in_rs2);
  assign w_ltu     = in_rs1 < in_rs2;
  assign w_illegal = in_f3[2:1] == 2'b01;
  assign w_target  = in_pc + in_imm;
  assign w_seq     = in_pc + {{(XLEN-3){1'b0}}, 3'd4};
  assign w_pred_unused = ^pred_pc;
  // funct3[0] inverts the base compare; funct3[2:1] selects eq / illegal / signed / unsigned
  always_comb
    w_taken = in_f3[2] ? ((in_f3[1] ? w_ltu : w_lt) ^ in_f3[0]) : (!in_f3[1] && (w_eq ^ in_f3[0]));
  assign out_valid        = r_valid;
  assign out_taken        = r_taken;
  assign out_target       = r_target;
  assign out_redirect_pc  = r_redirect;
  assign out_mispredict   = r_misp;
  assign out_illegal      = r_illegal;
  assign perf_branches    = r_nbr;
  assign perf_mispredicts = r_nmis;
  // result-valid flag: flush wins, accept refills, retire empties
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_valid <= 1'b0;
    else if (flush) r_valid <= 1'b0;
    else if (w_accept) r_valid <= 1'b1;
    else if (w_retire) r_valid <= 1'b0;
  // result fields load only on accept and hold otherwise
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_taken    <= 1'b0;
      r_misp     <= 1'b0;
      r_illegal  <= 1'b0;
      r_target   <= '0;
      r_redirect <= '0;
    end else if (w_accept) begin
      r_taken    <= w_taken;
      r_misp     <= w_taken ^ in_pred_taken;
      r_illegal  <= w_illegal;
      r_target   <= w_target;
      r_redirect <= w_taken ? w_target : w_seq;
    end
  // performance counters advance on retire and wrap naturally
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_nbr  <= '0;
      r_nmis <= '0;
    end else if (w_retire) begin
      r_nbr  <= r_nbr + 32'd1;
      r_nmis <= r_nmis + {31'd0, r_misp};
    end
`ifdef BRANCH_BHT_EN
  localparam int IW = $clog2(BHT_DEPTH);
  logic [1:0]    r_bht [BHT_DEPTH];
  logic [IW-1:0] r_idx;
  assign pred_taken = r_bht[pred_pc[IW+1:2]][1];
  // BHT index of the in-flight branch, captured alongside its result
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_idx <= '0;
    else if (w_accept) r_idx <= in_pc[IW+1:2];
  // saturating 2-bit counters trained by legal retiring branches
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < BHT_DEPTH; i++) r_bht[i] <= 2'b01;
    end else if (w_retire && !r_illegal) begin
      if (r_taken && r_bht[r_idx] != 2'b11) r_bht[r_idx] <= r_bht[r_idx] + 2'd1;
      else if (!r_taken && r_bht[r_idx] != 2'b00) r_bht[r_idx] <= r_bht[r_idx] - 2'd1;
    end
`else
  assign pred_taken = 1'b0;
`endif
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: vector table, hand sequences and randomized model check for branch_resolve_unit
module tb_branch_resolve_unit;
  logic        clk, rst_n, flush, in_valid, in_ready, in_pred_taken;
  logic [31:0] in_pc, in_rs1, in_rs2, in_imm, pred_pc;
  logic [2:0]  in_f3;
  logic        out_valid, out_ready, out_taken, out_mispredict, out_illegal, pred_taken;
  logic [31:0] out_target, out_redirect_pc, perf_branches, perf_mispredicts;

  branch_resolve_unit #(.XLEN(32), .BHT_DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_f3(in_f3),
    .in_pred_taken(in_pred_taken), .out_valid(out_valid), .out_ready(out_ready),
    .out_taken(out_taken), .out_target(out_target), .out_redirect_pc(out_redirect_pc),
    .out_mispredict(out_mispredict), .out_illegal(out_illegal), .pred_pc(pred_pc),
    .pred_taken(pred_taken), .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] rs1, rs2, pc, imm;
    logic        pred;
    logic        taken;
    logic [31:0] target, redir;
    logic        misp, ill;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t ref_eval(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                    input logic [31:0] pc, input logic [31:0] imm, input logic pred);
    vec_t v;
    int   sa, sb;
    sa = a;
    sb = b;
    v.f3 = f3; v.rs1 = a; v.rs2 = b; v.pc = pc; v.imm = imm; v.pred = pred;
    case (f3)
      3'd0: v.taken = (a == b);
      3'd1: v.taken = (a != b);
      3'd4: v.taken = (sa < sb);
      3'd5: v.taken = (sa >= sb);
      3'd6: v.taken = (a < b);
      3'd7: v.taken = (a >= b);
      default: v.taken = 1'b0;
    endcase
    v.ill    = (f3 == 3'd2) || (f3 == 3'd3);
    v.target = pc + imm;
    v.redir  = v.taken ? v.target : pc + 32'd4;
    v.misp   = (v.taken != pred);
    return v;
  endfunction

  task automatic drive(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] pc, input logic [31:0] imm, input logic pred);
    in_valid = 1; in_f3 = f3; in_rs1 = a; in_rs2 = b; in_pc = pc; in_imm = imm; in_pred_taken = pred;
  endtask

  task automatic issue_retire(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc);
    @(negedge clk); drive(f3, a, b, pc, 32'h10, 1'b0); out_ready = 1;
    @(negedge clk); in_valid = 0;
    @(negedge clk);
  endtask

  vec_t tbl[10];
  vec_t m;
  logic m_valid, e_ready, acc, ret;
  logic [31:0] m_nb, m_nm;
  logic [31:0] exp_nm;

  initial begin
    tbl[0] = '{3'd0, 32'h5, 32'h5, 32'h100, 32'h20, 1'b0, 1'b1, 32'h120, 32'h120, 1'b1, 1'b0};
    tbl[1] = '{3'd4, 32'hFFFFFFFF, 32'h1, 32'h200, 32'h10, 1'b1, 1'b1, 32'h210, 32'h210, 1'b0, 1'b0};
    tbl[2] = '{3'd6, 32'hFFFFFFFF, 32'h1, 32'h200, 32'h10, 1'b1, 1'b0, 32'h210, 32'h204, 1'b1, 1'b0};
    tbl[3] = '{3'd5, 32'hFFFFFFFF, 32'h1, 32'h200, 32'h10, 1'b0, 1'b0, 32'h210, 32'h204, 1'b0, 1'b0};
    tbl[4] = '{3'd7, 32'hFFFFFFFF, 32'h1, 32'h200, 32'h10, 1'b0, 1'b1, 32'h210, 32'h210, 1'b1, 1'b0};
    tbl[5] = '{3'd1, 32'h3, 32'h3, 32'hFFFFFFFC, 32'h8, 1'b0, 1'b0, 32'h4, 32'h0, 1'b0, 1'b0};
    tbl[6] = '{3'd0, 32'h7, 32'h7, 32'hFFFFFFFC, 32'h8, 1'b1, 1'b1, 32'h4, 32'h4, 1'b0, 1'b0};
    tbl[7] = '{3'd2, 32'h9, 32'h9, 32'h1000, 32'h40, 1'b1, 1'b0, 32'h1040, 32'h1004, 1'b1, 1'b1};
    tbl[8] = '{3'd3, 32'h1, 32'h2, 32'h2000, 32'hFFFFFFF0, 1'b0, 1'b0, 32'h1FF0, 32'h2004, 1'b0, 1'b1};
    tbl[9] = '{3'd1, 32'h1, 32'h2, 32'h3000, 32'h100, 1'b0, 1'b1, 32'h3100, 32'h3100, 1'b1, 1'b0};

    rst_n = 0; flush = 0; in_valid = 0; out_ready = 1; pred_pc = 32'h40;
    drive(3'd0, 0, 0, 0, 0, 0); in_valid = 0;
    #3;
    chk("rst out_valid", {31'd0, out_valid}, 0);
    chk("rst out_taken", {31'd0, out_taken}, 0);
    chk("rst out_misp", {31'd0, out_mispredict}, 0);
    chk("rst out_illegal", {31'd0, out_illegal}, 0);
    chk("rst out_target", out_target, 0);
    chk("rst out_redirect", out_redirect_pc, 0);
    chk("rst perf_branches", perf_branches, 0);
    chk("rst perf_mispredicts", perf_mispredicts, 0);
    chk("rst pred_taken", {31'd0, pred_taken}, 0);
    @(negedge clk); rst_n = 1;
    #1 chk("in_ready after reset", {31'd0, in_ready}, 1);

    exp_nm = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(tbl[i].f3, tbl[i].rs1, tbl[i].rs2, tbl[i].pc, tbl[i].imm, tbl[i].pred);
      @(negedge clk);
      in_valid = 0;
      chk($sformatf("vec%0d out_valid", i), {31'd0, out_valid}, 1);
      chk($sformatf("vec%0d out_taken", i), {31'd0, out_taken}, {31'd0, tbl[i].taken});
      chk($sformatf("vec%0d out_target", i), out_target, tbl[i].target);
      chk($sformatf("vec%0d out_redirect", i), out_redirect_pc, tbl[i].redir);
      chk($sformatf("vec%0d out_misp", i), {31'd0, out_mispredict}, {31'd0, tbl[i].misp});
      chk($sformatf("vec%0d out_illegal", i), {31'd0, out_illegal}, {31'd0, tbl[i].ill});
      chk($sformatf("vec%0d perf_branches", i), perf_branches, i);
      chk($sformatf("vec%0d perf_mispredicts", i), perf_mispredicts, exp_nm);
      exp_nm += {31'd0, tbl[i].misp};
    end
    @(negedge clk);
    chk("table perf_branches", perf_branches, 10);
    chk("table perf_mispredicts", perf_mispredicts, exp_nm);

    // backpressure: hold a taken beq for three stalled cycles
    drive(3'd0, 32'h1, 32'h1, 32'h300, 32'h40, 1'b1); out_ready = 0;
    @(negedge clk);
    drive(3'd1, 32'h1, 32'h1, 32'h500, 32'h8, 1'b1);
    for (int k = 0; k < 3; k++) begin
      chk("stall out_valid", {31'd0, out_valid}, 1);
      chk("stall in_ready", {31'd0, in_ready}, 0);
      chk("stall out_target", out_target, 32'h340);
      chk("stall out_redirect", out_redirect_pc, 32'h340);
      chk("stall perf_branches", perf_branches, 10);
      @(negedge clk);
    end
    out_ready = 1;
    #1 chk("unstall in_ready", {31'd0, in_ready}, 1);
    @(negedge clk);
    chk("b2b first out_valid", {31'd0, out_valid}, 1);
    chk("b2b first target", out_target, 32'h508);
    chk("b2b first redirect", out_redirect_pc, 32'h504);
    chk("b2b first perf_branches", perf_branches, 11);
    drive(3'd6, 32'h1, 32'h2, 32'h600, 32'h10, 1'b1);
    @(negedge clk);
    chk("b2b second out_valid", {31'd0, out_valid}, 1);
    chk("b2b second target", out_target, 32'h610);
    chk("b2b second perf_branches", perf_branches, 12);
    chk("b2b second perf_mispredicts", perf_mispredicts, exp_nm + 1);

    // flush with a pending result and a new request present
    drive(3'd0, 32'h2, 32'h2, 32'h700, 32'h20, 1'b0); flush = 1;
    #1 chk("flush in_ready", {31'd0, in_ready}, 0);
    @(negedge clk);
    flush = 0; in_valid = 0;
    chk("flush out_valid", {31'd0, out_valid}, 0);
    chk("flush not captured", out_target, 32'h610);
    chk("flush perf_branches", perf_branches, 12);
    @(negedge clk);
    chk("post flush perf_branches", perf_branches, 12);

    // asynchronous reset while stalled
    drive(3'd0, 32'h2, 32'h2, 32'h800, 32'h20, 1'b0); out_ready = 0;
    @(negedge clk);
    in_valid = 0;
    chk("prereset out_valid", {31'd0, out_valid}, 1);
    #2 rst_n = 0;
    #1;
    chk("async rst out_valid", {31'd0, out_valid}, 0);
    chk("async rst target", out_target, 0);
    chk("async rst taken", {31'd0, out_taken}, 0);
    chk("async rst perf_branches", perf_branches, 0);
    chk("async rst perf_mispredicts", perf_mispredicts, 0);
    @(negedge clk); rst_n = 1; out_ready = 1;
    @(negedge clk);
    chk("reset drop not counted", perf_branches, 0);

    // randomized phase against the reference model
    m = ref_eval(3'd0, 0, 0, 0, 0, 0);
    m.taken = 0; m.target = 0; m.redir = 0; m.misp = 0; m.ill = 0;
    m_valid = 0; m_nb = 0; m_nm = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      in_valid = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      flush = ($urandom_range(0, 19) == 0);
      in_f3 = 3'($urandom_range(0, 7));
      in_rs1 = $urandom;
      in_rs2 = ($urandom_range(0, 3) == 0) ? in_rs1 : (($urandom_range(0, 1) == 1) ? $urandom : in_rs1 ^ 32'h8000_0000);
      in_pc = $urandom;
      in_imm = $urandom;
      in_pred_taken = 1'($urandom_range(0, 1));
      pred_pc = $urandom;
      #1;
      e_ready = !flush && (!m_valid || out_ready);
      chk("rand in_ready", {31'd0, in_ready}, {31'd0, e_ready});
`ifndef BRANCH_BHT_EN
      chk("rand pred_taken tied", {31'd0, pred_taken}, 0);
`endif
      acc = in_valid && e_ready;
      ret = m_valid && out_ready && !flush;
      if (ret) begin
        m_nb++;
        if (m.misp) m_nm++;
      end
      if (acc) m = ref_eval(in_f3, in_rs1, in_rs2, in_pc, in_imm, in_pred_taken);
      m_valid = flush ? 1'b0 : acc ? 1'b1 : ret ? 1'b0 : m_valid;
      @(posedge clk);
      #1;
      chk("rand out_valid", {31'd0, out_valid}, {31'd0, m_valid});
      chk("rand out_taken", {31'd0, out_taken}, {31'd0, m.taken});
      chk("rand out_target", out_target, m.target);
      chk("rand out_redirect", out_redirect_pc, m.redir);
      chk("rand out_misp", {31'd0, out_mispredict}, {31'd0, m.misp});
      chk("rand out_illegal", {31'd0, out_illegal}, {31'd0, m.ill});
      chk("rand perf_branches", perf_branches, m_nb);
      chk("rand perf_mispredicts", perf_mispredicts, m_nm);
    end
    @(negedge clk);
    flush = 0; in_valid = 0; out_ready = 1;

`ifdef BRANCH_BHT_EN
    rst_n = 0;
    #2 rst_n = 1;
    pred_pc = 32'h40;
    #1 chk("bht init", {31'd0, pred_taken}, 0);
    issue_retire(3'd0, 1, 1, 32'h40);
    chk("bht 01->10", {31'd0, pred_taken}, 1);
    issue_retire(3'd0, 1, 1, 32'h40);
    chk("bht 10->11", {31'd0, pred_taken}, 1);
    pred_pc = 32'h44;
    #1 chk("bht other entry", {31'd0, pred_taken}, 0);
    pred_pc = 32'h40;
    issue_retire(3'd0, 1, 2, 32'h40);
    chk("bht 11->10", {31'd0, pred_taken}, 1);
    issue_retire(3'd0, 1, 2, 32'h40);
    chk("bht 10->01", {31'd0, pred_taken}, 0);
    issue_retire(3'd0, 1, 2, 32'h40);
    chk("bht 01->00", {31'd0, pred_taken}, 0);
    issue_retire(3'd2, 1, 1, 32'h40);
    issue_retire(3'd0, 1, 1, 32'h40);
    chk("bht illegal ignored", {31'd0, pred_taken}, 0);
    issue_retire(3'd0, 1, 1, 32'h40);
    chk("bht 01->10 again", {31'd0, pred_taken}, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Parametrised, pipelined branch resolution unit for the RISC-V core. It accepts a decoded conditional branch (PC, rs1, rs2, immediate, funct3, fetch prediction) over a valid/ready handshake and evaluates all six RV32I/RV64I branch conditions at XLEN width. One cycle later it presents the registered outcome: taken flag, target, redirect PC and mispredict flag. An optional 2-bit branch history table gives fetch a prediction and is trained on every retired branch.

## Interface
Parameters:
- XLEN, 32, datapath width in bits (32 or 64).
- BHT_DEPTH, 16, BHT entries; power of two, at least 2. Used only with BRANCH_BHT_EN.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  pipeline flush; discards the in-flight result.
- in_valid  in  1  branch request valid.
- in_ready  out  1  unit can accept a request.
- in_pc  in  XLEN  branch instruction PC.
- in_rs1, in_rs2  in  XLEN  operands.
- in_imm  in  XLEN  sign-extended B-immediate.
- in_f3  in  3  funct3.
- in_pred_taken  in  1  prediction that fetch used.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_taken  out  1  condition true.
- out_target  out  XLEN  in_pc + in_imm.
- out_redirect_pc  out  XLEN  next correct PC.
- out_mispredict  out  1  out_taken differs from in_pred_taken.
- out_illegal  out  1  funct3 is 010 or 011.
- pred_pc  in  XLEN  fetch-side lookup PC.
- pred_taken  out  1  BHT prediction for pred_pc (combinational).
- perf_branches  out  32  count of retired branches.
- perf_mispredicts  out  32  count of retired mispredicts.

## Operation
- Branch conditions by funct3:
  - 000 beq: rs1 == rs2.
  - 001 bne: rs1 != rs2.
  - 100 blt: signed rs1 < rs2.
  - 101 bge: signed rs1 >= rs2.
  - 110 bltu: unsigned rs1 < rs2.
  - 111 bgeu: unsigned rs1 >= rs2.
  - 010 and 011: out_taken = 0, out_illegal = 1, out_mispredict = in_pred_taken.
- Arithmetic, all modulo 2^XLEN:
  - out_target = in_pc + in_imm.
  - out_redirect_pc = out_taken ? out_target : in_pc + 4.
- Output register stage:
  - in_ready = !flush && (!out_valid || out_ready).
  - Accept when in_valid && in_ready; all result fields are loaded at that edge.
- Retire is out_valid && out_ready && !flush. On retire:
  - perf_branches increments.
  - perf_mispredicts increments if out_mispredict.
  - Both counters wrap at 2^32.
- Flush:
  - out_valid is 0 at the next edge.
  - Nothing is accepted in the flush cycle.
  - No counter or BHT update in the flush cycle.
- Output data fields hold their value while out_valid = 0 and while a result is stalled (out_ready = 0).

## Timing
- Latency is 1 cycle from accept to out_valid.
- Throughput is 1 per cycle while out_ready = 1.
- Simultaneous retire and accept: the new result replaces the old one at the same edge, with no bubble.
- Reset, asynchronous and immediate:
  - out_valid, out_taken, out_mispredict, out_illegal = 0.
  - out_target, out_redirect_pc = 0.
  - perf counters = 0.
  - BHT entries = 2'b01.
  - in_ready becomes 1 once rst_n deasserts.
- Reset while a result is pending: the result is dropped and not counted.

## Configuration
- Macro: BRANCH_BHT_EN.
- Defined:
  - BHT_DEPTH 2-bit saturating counters, indexed by PC bits [log2(BHT_DEPTH)+1:2].
  - pred_taken = counter[1] of the entry for pred_pc.
  - On retire, the entry for the retired in_pc (a copy is registered at accept) is updated: taken increments to a maximum of 11, not taken decrements to a minimum of 00.
  - Illegal funct3 does not update the BHT.
  - If a lookup and an update hit the same index in one cycle, pred_taken shows the pre-update value.
- Undefined: no BHT storage, pred_taken tied to 0, pred_pc ignored.

## Test plan
- beq with rs1 = rs2 = 0x5, pc = 0x100, imm = 0x20, pred_taken = 0 -> next cycle: out_taken = 1, out_target = 0x120, out_redirect_pc = 0x120, out_mispredict = 1, perf_mispredicts = 1 after retire.
- blt with rs1 = 0xFFFFFFFF, rs2 = 1 -> taken; bltu with the same operands -> not taken, out_redirect_pc = pc + 4. bge and bgeu give the complements.
- Wrap-around: pc = 0xFFFFFFFC, imm = 8 -> out_target = 0x4. Not-taken case gives out_redirect_pc = 0x0.
- Backpressure: out_ready = 0 for 3 cycles -> in_ready = 0, outputs stable, no counter change. Then out_ready = 1 with in_valid = 1 -> back-to-back results, no bubble.
- Flush with out_valid = 1 and in_valid = 1 -> out_valid = 0 next cycle, input not captured, counters unchanged. rst_n pulse mid-stall clears everything asynchronously.
- With BRANCH_BHT_EN: pc = 0x40 taken 2 times -> entry goes 01 -> 10 -> 11 and pred_taken(0x40) = 1. 3 not-taken retires -> entry reaches 00 and pred_taken = 0. Funct3 = 010 leaves the entry unchanged.
